// File: rtl/accum_drv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accum_drv_pkg
// Description : Shared types and default sizes for the accumulate-kernel
//               driver (state encoding, array depth and word widths).
// Revision    : 1.0 - initial release
// ============================================================================
package accum_drv_pkg;

  localparam int c_depth_default = 1000;  // kernel array depth in words
  localparam int c_aw_default    = 10;    // array address width
  localparam int c_dw_default    = 64;    // signed data word width
  localparam int c_tmo_w_default = 16;    // watchdog counter width

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage : accum_drv_pkg
`default_nettype wire

// File: rtl/accum_drv_skid.sv
`default_nettype none
// ============================================================================
// Module      : accum_drv_skid
// Description : 2-entry valid/ready FIFO carrying a data word plus a "last"
//               flag. Absorbs read data that is already in flight when the
//               downstream consumer stalls.
// Ports       : clk, rst_n (sync, active low)
//               in_valid/in_ready/in_data/in_last    - push side
//               out_valid/out_ready/out_data/out_last - pop side (head entry)
//               count                                 - current occupancy 0..2
// Revision    : 1.0 - initial release
// ============================================================================
module accum_drv_skid
  import accum_drv_pkg::*;
#(
  parameter int DW = c_dw_default
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [1:0]    count
);

  logic [DW:0] r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        w_push;
  logic        w_pop;

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign {out_last, out_data} = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {in_last, in_data};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule : accum_drv_skid
`default_nettype wire

// File: rtl/accum_kernel_driver.sv
`default_nettype none
// ============================================================================
// Module      : accum_kernel_driver
// Description : Host-side initiator for the accumulate kernel. Loads N words
//               into the kernel array, pulses r_enable with the initial
//               arguments, waits for w_enable, streams the array back out
//               and reports the kernel's scalar result.
// Ports       : clk, rst_n (sync, active low)
//               cmd_*   - command (n, init_i, init_acc), accepted in IDLE
//               in_*    - load stream into the kernel array
//               out_*   - drain stream out of the kernel array
//               resp_*  - one-cycle completion pulse, result, watchdog error
//               k_*     - kernel start/done handshake and array control port
// Options     : ACCUM_DRV_WATCHDOG_EN - RUN timeout forcing DONE with
//               resp_err=1; without it RUN waits forever and resp_err=0.
// Revision    : 1.0 - initial release
// ============================================================================
module accum_kernel_driver
  import accum_drv_pkg::*;
#(
  parameter int DEPTH = c_depth_default,
  parameter int AW    = c_aw_default,
  parameter int DW    = c_dw_default,
  parameter int TMO_W = c_tmo_w_default
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW:0]   cmd_n,
  input  logic [AW-1:0] cmd_init_i,
  input  logic [DW-1:0] cmd_init_acc,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          resp_valid,
  output logic          resp_result,
  output logic          resp_err,
  output logic          k_r_enable,
  output logic [AW-1:0] k_init_i,
  output logic [DW-1:0] k_init_acc,
  input  logic          k_w_enable,
  input  logic          k_result,
  output logic          k_controlArr,
  output logic          k_wen,
  output logic [AW-1:0] k_addr,
  output logic [DW-1:0] k_wdata,
  input  logic [DW-1:0] k_rdata
);

  localparam logic [AW:0] c_depth_n = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_n_one   = {{AW{1'b0}}, 1'b1};

  state_e        r_state;
  logic [AW:0]   r_n;
  logic [AW-1:0] r_init_i;
  logic [DW-1:0] r_init_acc;
  logic [AW-1:0] r_cnt;
  logic          r_rd_done;
  logic          r_inflight;
  logic          r_inflight_last;

  logic [AW:0]   w_n_sat;
  logic          w_cnt_last;
  logic          w_load_hs;
  logic          w_out_hs;
  logic          w_rd_issue;
  logic [2:0]    w_occ;
  logic [1:0]    w_skid_count;
  logic          w_skid_in_ready;

`ifdef ACCUM_DRV_WATCHDOG_EN
  logic [TMO_W-1:0] r_tmo;
  logic             r_resp_err;
  assign resp_err = r_resp_err;
`else
  assign resp_err = 1'b0;
`endif

  assign w_n_sat    = (cmd_n > c_depth_n) ? c_depth_n : cmd_n;
  assign w_cnt_last = ({1'b0, r_cnt} == (r_n - c_n_one));
  assign w_load_hs  = in_valid & in_ready;
  assign w_out_hs   = out_valid & out_ready;

  // Skid occupancy plus the read still in flight. A word popped this cycle
  // frees a slot immediately, which is what sustains one word per cycle.
  assign w_occ      = {1'b0, w_skid_count} + {2'b00, r_inflight};
  assign w_rd_issue = (r_state == DRAIN) & ~r_rd_done & ((w_occ < 3'd2) | w_out_hs);

  // Array port strobes follow the handshakes combinationally.
  assign k_wen   = w_load_hs;
  assign k_addr  = (w_load_hs || w_rd_issue) ? r_cnt : '0;
  assign k_wdata = w_load_hs ? in_data : '0;

  // Read data returns one cycle after its address; the credit check above
  // guarantees the skid always has room, so in_ready is effectively 1.
  accum_drv_skid #(
    .DW (DW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (r_inflight & w_skid_in_ready),
    .in_ready  (w_skid_in_ready),
    .in_data   (k_rdata),
    .in_last   (r_inflight_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .count     (w_skid_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      cmd_ready       <= 1'b0;
      in_ready        <= 1'b0;
      resp_valid      <= 1'b0;
      resp_result     <= 1'b0;
      k_r_enable      <= 1'b0;
      k_controlArr    <= 1'b0;
      k_init_i        <= '0;
      k_init_acc      <= '0;
      r_n             <= '0;
      r_init_i        <= '0;
      r_init_acc      <= '0;
      r_cnt           <= '0;
      r_rd_done       <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
`ifdef ACCUM_DRV_WATCHDOG_EN
      r_tmo           <= '0;
      r_resp_err      <= 1'b0;
`endif
    end else begin
      r_inflight      <= w_rd_issue;
      r_inflight_last <= w_rd_issue & w_cnt_last;

      case (r_state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready  <= 1'b0;
            r_n        <= w_n_sat;
            r_init_i   <= cmd_init_i;
            r_init_acc <= cmd_init_acc;
            r_cnt      <= '0;
`ifdef ACCUM_DRV_WATCHDOG_EN
            r_resp_err <= 1'b0;
`endif
            if (w_n_sat == '0) begin
              // Nothing to load: start the kernel straight from the command.
              r_state    <= START;
              k_r_enable <= 1'b1;
              k_init_i   <= cmd_init_i;
              k_init_acc <= cmd_init_acc;
            end else begin
              r_state      <= LOAD;
              in_ready     <= 1'b1;
              k_controlArr <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (w_load_hs) begin
            if (w_cnt_last) begin
              r_cnt        <= '0;
              in_ready     <= 1'b0;
              k_controlArr <= 1'b0;
              k_r_enable   <= 1'b1;
              k_init_i     <= r_init_i;
              k_init_acc   <= r_init_acc;
              r_state      <= START;
            end else begin
              r_cnt <= r_cnt + AW'(1);
            end
          end
        end

        START: begin
          k_r_enable <= 1'b0;
          r_state    <= RUN;
`ifdef ACCUM_DRV_WATCHDOG_EN
          r_tmo      <= '0;
`endif
        end

        // k_w_enable from a previous run is still high during START; the
        // kernel clears it on the r_enable edge, so RUN only sees fresh done.
        RUN: begin
          if (k_w_enable) begin
            resp_result <= k_result;
            if (r_n == '0) begin
              resp_valid <= 1'b1;
              r_state    <= DONE;
            end else begin
              k_controlArr <= 1'b1;
              r_rd_done    <= 1'b0;
              r_cnt        <= '0;
              r_state      <= DRAIN;
            end
          end
`ifdef ACCUM_DRV_WATCHDOG_EN
          else if (r_tmo == '1) begin
            resp_err_set: begin
              r_resp_err  <= 1'b1;
              resp_result <= 1'b0;
              resp_valid  <= 1'b1;
              r_state     <= DONE;
            end
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
`endif
        end

        DRAIN: begin
          if (w_rd_issue) begin
            if (w_cnt_last) begin
              r_rd_done <= 1'b1;
              r_cnt     <= '0;
            end else begin
              r_cnt <= r_cnt + AW'(1);
            end
          end
          if (w_out_hs && out_last) begin
            k_controlArr <= 1'b0;
            resp_valid   <= 1'b1;
            r_state      <= DONE;
          end
        end

        DONE: begin
          resp_valid <= 1'b0;
          cmd_ready  <= 1'b1;
          r_state    <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : accum_kernel_driver
`default_nettype wire

// File: tb/tb_accum_kernel_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_kernel_driver
// Description : Self-checking bench for accum_kernel_driver with a simple
//               kernel model (array with 1-cycle read, delayed done) and a
//               queue-based reference of the words that must be written and
//               drained back.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_accum_kernel_driver;

  localparam int DEPTH = 1000;
  localparam int AW    = 10;
  localparam int DW    = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW:0]   cmd_n = '0;
  logic [AW-1:0] cmd_init_i = '0;
  logic [DW-1:0] cmd_init_acc = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          resp_valid;
  logic          resp_result;
  logic          resp_err;
  logic          k_r_enable;
  logic [AW-1:0] k_init_i;
  logic [DW-1:0] k_init_acc;
  logic          k_w_enable = 1'b0;
  logic          k_result = 1'b0;
  logic          k_controlArr;
  logic          k_wen;
  logic [AW-1:0] k_addr;
  logic [DW-1:0] k_wdata;
  logic [DW-1:0] k_rdata = '0;

  always #5 clk = ~clk;

  accum_kernel_driver #(
    .DEPTH (DEPTH), .AW (AW), .DW (DW), .TMO_W (16)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_n (cmd_n),
    .cmd_init_i (cmd_init_i), .cmd_init_acc (cmd_init_acc),
    .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
    .out_last (out_last),
    .resp_valid (resp_valid), .resp_result (resp_result), .resp_err (resp_err),
    .k_r_enable (k_r_enable), .k_init_i (k_init_i), .k_init_acc (k_init_acc),
    .k_w_enable (k_w_enable), .k_result (k_result),
    .k_controlArr (k_controlArr), .k_wen (k_wen), .k_addr (k_addr),
    .k_wdata (k_wdata), .k_rdata (k_rdata)
  );

  // ---------------- kernel model ----------------
  logic [DW-1:0] kmem [DEPTH];
  int  k_cd  = 0;
  int  k_lat = 1;
  bit  k_res = 1'b0;
  int  cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (k_controlArr) begin
      if (k_wen && int'(k_addr) < DEPTH) kmem[k_addr] <= k_wdata;
      k_rdata <= (int'(k_addr) < DEPTH) ? kmem[k_addr] : '0;
    end
    if (k_r_enable) begin
      k_w_enable <= 1'b0;
      k_cd       <= k_lat;
    end else if (k_cd > 0) begin
      k_cd <= k_cd - 1;
      if (k_cd == 1) begin
        k_w_enable <= 1'b1;
        k_result   <= k_res;
      end
    end
  end

  // ---------------- reference and monitors ----------------
  logic [DW-1:0] exp_q [$];
  int wr_cnt, wr_err, ren_cnt, carr_err, out_cnt, out_err, last_err;
  int first_out_cyc, last_out_cyc, resp_cnt, resp_cyc, wen_cyc;
  bit wen_seen;
  bit resp_res_seen, resp_err_seen;
  logic [AW-1:0] ren_init_i;
  logic [DW-1:0] ren_init_acc;

  always @(negedge clk) begin
    if (rst_n) begin
      if (k_wen) begin
        if (!k_controlArr || int'(k_addr) != wr_cnt || wr_cnt >= exp_q.size() ||
            k_wdata != exp_q[wr_cnt]) wr_err++;
        wr_cnt++;
      end
      if (k_r_enable) begin
        ren_cnt++;
        ren_init_i   = k_init_i;
        ren_init_acc = k_init_acc;
        wen_seen     = 1'b0;
      end else if (k_w_enable && !wen_seen) begin
        wen_seen = 1'b1;
        wen_cyc  = cyc;
      end
      if (k_controlArr && (k_r_enable || k_cd > 0)) carr_err++;
      if (out_valid && out_ready) begin
        if (out_cnt >= exp_q.size() || out_data != exp_q[out_cnt]) out_err++;
        if (out_last != (out_cnt == exp_q.size() - 1)) last_err++;
        if (out_cnt == 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        out_cnt++;
      end
      if (resp_valid) begin
        resp_cnt++;
        resp_cyc      = cyc;
        resp_res_seen = resp_result;
        resp_err_seen = resp_err;
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    int            n;
    int            exp_nsat;
    logic [AW-1:0] init_i;
    logic [DW-1:0] init_acc;
    int            lat;
    bit            res;
    int            mode;  // out_ready: 0 always, 1 toggle, 2 toggle + 5-low windows, 3 random
    int            gap;   // idle cycles before each load word, -1 random 0..2
    bit            seq;   // load data 1,2,3,... instead of random
  } txn_t;

  function automatic logic ready_for(input int mode);
    case (mode)
      0:       return 1'b1;
      1:       return cyc[0];
      2:       return ((cyc % 16) < 5) ? 1'b0 : cyc[0];
      default: return 1'($urandom_range(1, 0));
    endcase
  endfunction

  task automatic run_txn(input txn_t t, input int abort_at);
    bit hs;
    int gap;
    exp_q.delete();
    for (int i = 0; i < t.exp_nsat; i++)
      exp_q.push_back(t.seq ? DW'(i + 1) : {$urandom, $urandom});
    wr_cnt = 0; wr_err = 0; ren_cnt = 0; carr_err = 0; out_cnt = 0;
    out_err = 0; last_err = 0; resp_cnt = 0; wen_seen = 1'b1; wen_cyc = 0;
    first_out_cyc = 0; last_out_cyc = 0; resp_cyc = 0;
    k_lat = t.lat; k_res = t.res; out_ready = 1'b0;

    cmd_valid = 1'b1; cmd_n = (AW+1)'(t.n);
    cmd_init_i = t.init_i; cmd_init_acc = t.init_acc;
    hs = 1'b0;
    for (int b = 0; b < 50 && !hs; b++) begin
      @(negedge clk); hs = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", 64'(hs), 64'd1);
    if (!hs) return;

    for (int i = 0; i < t.exp_nsat; i++) begin
      in_valid = 1'b0;
      gap = (t.gap < 0) ? int'($urandom_range(2, 0)) : t.gap;
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
      in_valid = 1'b1; in_data = exp_q[i];
      hs = 1'b0;
      for (int b = 0; b < 50 && !hs; b++) begin
        @(negedge clk); hs = in_ready;
        @(posedge clk); #1;
      end
      if (!hs) begin
        in_valid = 1'b0;
        check("load_timeout", 64'(i), 64'(t.exp_nsat));
        return;
      end
    end
    in_valid = 1'b0;

    for (int b = 0; b < 8000 && resp_cnt == 0; b++) begin
      out_ready = ready_for(t.mode);
      @(posedge clk); #1;
      if (abort_at >= 0 && out_cnt > abort_at) begin
        rst_n = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        check("rst_out_valid",  64'(out_valid),    64'd0);
        check("rst_ctrlarr",    64'(k_controlArr), 64'd0);
        check("rst_wen",        64'(k_wen),        64'd0);
        check("rst_resp_res",   64'(resp_result),  64'd0);
        check("rst_cmd_ready",  64'(cmd_ready),    64'd0);
        check("rst_r_enable",   64'(k_r_enable),   64'd0);
        rst_n = 1'b1;
        return;
      end
    end
    out_ready = 1'b0;
    check("resp_count",   64'(resp_cnt),      64'd1);
    check("resp_pulse",   64'(resp_valid),    64'd0);
    check("resp_result",  64'(resp_res_seen), 64'(t.res));
    check("resp_err",     64'(resp_err_seen), 64'd0);
    check("write_count",  64'(wr_cnt),        64'(t.exp_nsat));
    check("write_errs",   64'(wr_err),        64'd0);
    check("r_enable_cyc", 64'(ren_cnt),       64'd1);
    check("init_i",       64'(ren_init_i),    64'(t.init_i));
    check("init_acc",     64'(ren_init_acc),  64'(t.init_acc));
    check("ctrlarr_run",  64'(carr_err),      64'd0);
    check("out_count",    64'(out_cnt),       64'(t.exp_nsat));
    check("out_data",     64'(out_err),       64'd0);
    check("out_last",     64'(last_err),      64'd0);
    if (t.exp_nsat > 0) begin
      check("drain_after_done", 64'(first_out_cyc > wen_cyc), 64'd1);
      if (t.mode == 0 && t.exp_nsat > 1)
        check("drain_rate", 64'(last_out_cyc - first_out_cyc), 64'(t.exp_nsat - 1));
    end else begin
      check("resp_after_done", 64'(resp_cyc > wen_cyc), 64'd1);
    end
  endtask

  txn_t tbl [8];
  txn_t t;

  initial begin
    //        n     nsat  init_i  init_acc              lat res mode gap seq
    tbl[0] = '{4,    4,    10'd0,  64'd5,                20, 1,  0,   0,  1};
    tbl[1] = '{8,    8,    10'd7,  64'hFFFF_FFFF_FFFF_FFFE, 5, 0, 1,  0,  0};
    tbl[2] = '{8,    8,    10'd3,  64'd100,              9,  1,  2,   0,  0};
    tbl[3] = '{1000, 1000, 10'd999,64'd1,                3,  1,  0,   0,  0};
    tbl[4] = '{1023, 1000, 10'd1,  64'd2,                4,  0,  3,  -1,  0};
    tbl[5] = '{0,    0,    10'd5,  64'd77,               7,  1,  0,   0,  0};
    tbl[6] = '{6,    6,    10'd2,  64'd3,                2,  0,  0,   3,  0};
    tbl[7] = '{1,    1,    10'd9,  64'h8000_0000_0000_0000, 11, 1, 3, -1, 0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_cmd_ready", 64'(cmd_ready),    64'd0);
    check("reset_in_ready",  64'(in_ready),     64'd0);
    check("reset_out_valid", 64'(out_valid),    64'd0);
    check("reset_resp",      64'(resp_valid),   64'd0);
    check("reset_r_enable",  64'(k_r_enable),   64'd0);
    check("reset_ctrlarr",   64'(k_controlArr), 64'd0);
    check("reset_wen",       64'(k_wen),        64'd0);
    check("reset_result",    64'(resp_result),  64'd0);
    check("reset_err",       64'(resp_err),     64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(tbl[i], -1);

    for (int i = 0; i < 6; i++) begin
      t.n = int'($urandom_range(40, 0)); t.exp_nsat = t.n;
      t.init_i = AW'($urandom); t.init_acc = {$urandom, $urandom};
      t.lat = int'($urandom_range(25, 1)); t.res = 1'($urandom);
      t.mode = 3; t.gap = -1; t.seq = 1'b0;
      run_txn(t, -1);
    end

    // Reset while draining word 3; the kernel keeps w_enable=1 afterwards.
    t = '{8, 8, 10'd4, 64'd42, 6, 1, 0, 0, 0};
    run_txn(t, 3);
    check("stale_wen_high", 64'(k_w_enable), 64'd1);
    t = '{5, 5, 10'd6, 64'd9, 15, 0, 1, 0, 0};
    run_txn(t, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_accum_kernel_driver
`default_nettype wire
